axi_lite_master: RTL and testbench

- Upstream AXI4-Lite bus master. Converts single-beat local commands (cmd_*) into AXI4-Lite read or write transactions and returns the completion on a rsp_* channel.
- Drives the AXI4-Lite slave controller in the register-access subsystem.
- One transaction is outstanding at a time. AW and W are issued together and retire independently.
- A timeout counter recovers from a slave that never completes.

---
 rtl/axi_lite_master.sv | 193 +++++++++++++++++++
 tb/tb_axi_lite_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master turning cmd_* requests into AW/W/B or AR/R
// transactions, with a timeout that forces a completion when the slave stalls.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_timeout_q, rsp_timeout_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] cnt_q, cnt_d;
  logic busy, to, aw_hs, w_hs;
  always_comb begin
    state_d = state_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d = bready_q;
    rready_d = rready_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_resp_d = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    busy = state_q inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
    cnt_d = busy ? cnt_q + 32'd1 : cnt_q;
    to = (TIMEOUT != 0) && busy && (cnt_d == TO_LIM);
    aw_hs = awvalid_q && awready;
    w_hs = wvalid_q && wready;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        cnt_d = '0;
        rsp_timeout_d = 1'b0;
        if (cmd_write) begin
          awaddr_d = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          awvalid_d = 1'b1;
          wvalid_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
          state_d = WR_ADDR_DATA;
        end else begin
          araddr_d = cmd_addr;
          arvalid_d = 1'b1;
          state_d = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (bvalid && bready_q) begin
        bready_d = 1'b0;
        rsp_resp_d = bresp;
        rsp_rdata_d = '0;
        rsp_write_d = 1'b1;
        rsp_valid_d = 1'b1;
        state_d = RSP;
      end
      RD_ADDR: if (arvalid_q && arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (rvalid && rready_q) begin
        rready_d = 1'b0;
        rsp_rdata_d = rdata;
        rsp_resp_d = rresp;
        rsp_write_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a B/R handshake landing in the timeout cycle already moved us to RSP and takes priority
    if (to && state_d != RSP) begin
      awvalid_d = 1'b0;
      wvalid_d = 1'b0;
      arvalid_d = 1'b0;
      bready_d = 1'b0;
      rready_d = 1'b0;
      rsp_resp_d = 2'b10;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_write_d = state_q inside {WR_ADDR_DATA, WR_RESP};
      rsp_valid_d = 1'b1;
      state_d = RSP;
    end
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      {cmd_ready_q, awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q} <= '0;
      {aw_done_q, w_done_q, rsp_valid_q, rsp_write_q, rsp_timeout_q} <= '0;
      rsp_resp_q <= '0;
      rsp_rdata_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awaddr_q <= '0;
      araddr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      {cmd_ready_q, awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q} <=
        {cmd_ready_d, awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d};
      {aw_done_q, w_done_q, rsp_valid_q, rsp_write_q, rsp_timeout_q} <=
        {aw_done_d, w_done_d, rsp_valid_d, rsp_write_d, rsp_timeout_d};
      rsp_resp_q <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      cnt_q <= cnt_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign awvalid = awvalid_q;
  assign wvalid = wvalid_q;
  assign arvalid = arvalid_q;
  assign bready = bready_q;
  assign rready = rready_q;
  assign awaddr = awaddr_q;
  assign araddr = araddr_q;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench; a configurable slave model answers the DUT and
// expected completions are queued at command time and checked at the rsp handshake.
module tb_axi_lite_master;
  logic aclk, aresetn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  int aw_beats = 0, w_beats = 0, b_pulses = 0;
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0, rsp_hold = 0;
  logic b_never = 0;
  logic [31:0] rdata_v = 0;
  logic [1:0] rresp_v = 0, bresp_v = 0;
  logic [31:0] exp_awaddr = 0, exp_wdata = 0;
  logic [3:0] exp_wstrb = 0;

  initial aclk = 0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // slave model and response consumer, driven 2ns after each rising edge
  initial begin
    int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, h_n = 0;
    {awready, wready, bvalid, arready, rvalid, rsp_ready} = '0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(posedge aclk); #2;
      awready = awvalid && aw_n >= aw_lat; aw_n = awvalid ? aw_n + 1 : 0;
      wready = wvalid && w_n >= w_lat; w_n = wvalid ? w_n + 1 : 0;
      arready = arvalid && ar_n >= ar_lat; ar_n = arvalid ? ar_n + 1 : 0;
      bvalid = bready && !b_never && b_n >= b_lat; b_n = bready ? b_n + 1 : 0;
      bresp = bvalid ? bresp_v : 2'b11;
      rvalid = rready && r_n >= r_lat; r_n = rready ? r_n + 1 : 0;
      rdata = rvalid ? rdata_v : 32'hFFFF_FFFF;
      rresp = rvalid ? rresp_v : 2'b11;
      rsp_ready = rsp_valid && h_n >= rsp_hold; h_n = rsp_valid ? h_n + 1 : 0;
    end
  end

  // mid-cycle monitor: handshakes seen here complete at the next rising edge
  initial begin
    logic b_prev = 0, v_prev = 0;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (awvalid) chk("awaddr_stable", awaddr, exp_awaddr);
        if (awvalid && awready) aw_beats++;
        if (wvalid && wready) begin
          w_beats++;
          chk("wdata", wdata, exp_wdata);
          chk("wstrb", wstrb, exp_wstrb);
        end
        if (bready && !b_prev) b_pulses++;
        if (rready) chk("rready_excl_ar", arvalid, 0);
        if (rsp_valid && !v_prev) begin
          chk("rsp_axi_idle", {awvalid, wvalid, bready, arvalid, rready}, 0);
          if (exp_q.size() != 0) chk("rsp_lat", cyc - acc_cyc + 1, exp_q[0].lat);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_write", rsp_write, e.w);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_timeout", rsp_timeout, e.to);
          end
        end
      end
      b_prev = bready;
      v_prev = rsp_valid;
    end
  end

  task automatic do_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] erd, input logic [1:0] eresp,
                        input logic eto, input int elat);
    int n = 0;
    logic rdy;
    exp_q.push_back('{w: w, rdata: erd, resp: eresp, to: eto, lat: elat});
    exp_awaddr = addr; exp_wdata = wd; exp_wstrb = ws;
    @(posedge aclk); #2;
    cmd_write = w; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1;
    do begin
      @(negedge aclk); rdy = cmd_ready;
      @(posedge aclk); n++;
    end while (!rdy && n < 50);
    #2;
    acc_cyc = cyc;
    cmd_valid = 0;
    if (!rdy) chk("cmd_accept", 0, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge aclk); n++;
    end
    if (exp_q.size() != 0) chk("rsp_wait", exp_q.size(), 0);
    @(posedge aclk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0, b0, n;
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_data", {awaddr, araddr, wdata, wstrb, rsp_rdata}, 0);
    chk("rst_rsp", {rsp_resp, rsp_write, rsp_timeout}, 0);
    repeat (2) @(posedge aclk);
    #2 aresetn = 1;
    @(posedge aclk); #2;
    chk("idle_cmd_ready", cmd_ready, 1);

    // basic write against an always-ready slave
    aw0 = aw_beats; w0 = w_beats; b0 = b_pulses;
    do_cmd(1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 2'b00, 0, 3);
    wait_rsp();
    chk("wr1_aw_beats", aw_beats - aw0, 1);
    chk("wr1_w_beats", w_beats - w0, 1);

    // W completes three cycles before AW; bresp SLVERR passes through
    aw_lat = 3; bresp_v = 2'b10;
    aw0 = aw_beats; w0 = w_beats; b0 = b_pulses;
    do_cmd(1, 32'h30, 32'h0BAD_F00D, 4'h5, 0, 2'b10, 0, 6);
    repeat (2) @(posedge aclk); #2;
    chk("wr2_wvalid_dropped", wvalid, 0);
    chk("wr2_awvalid_held", awvalid, 1);
    wait_rsp();
    chk("wr2_aw_beats", aw_beats - aw0, 1);
    chk("wr2_w_beats", w_beats - w0, 1);
    chk("wr2_b_pulses", b_pulses - b0, 1);
    aw_lat = 0; bresp_v = 2'b00;

    // read, rvalid two cycles after the AR handshake
    r_lat = 1; rdata_v = 32'hDEAD_BEEF; rresp_v = 2'b00;
    do_cmd(0, 32'h24, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 4);
    chk("rd_rready_in_rd_addr", rready, 0);
    chk("rd_araddr", araddr, 32'h24);
    wait_rsp();
    r_lat = 0;

    // consumer stalls rsp for 5 cycles while a new command is offered
    rsp_hold = 5; rdata_v = 32'h1234_5678; rresp_v = 2'b01;
    do_cmd(0, 32'h40, 0, 0, 32'h1234_5678, 2'b01, 0, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge aclk); #2; n++;
    end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h99; cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", {rsp_rdata, rsp_resp, rsp_write}, {32'h1234_5678, 2'b01, 1'b0});
      @(posedge aclk); #2;
    end
    n = 0;
    while (rsp_valid && n < 20) begin
      @(posedge aclk); #2; n++;
    end
    cmd_valid = 0;
    rsp_hold = 0;
    repeat (3) @(posedge aclk); #2;
    chk("hold_cmd_ignored", {awvalid, wvalid, arvalid}, 0);
    chk("hold_cmd_ready_back", cmd_ready, 1);

    // slave never answers B: timeout forces a 2'b10 completion, then a normal write
    b_never = 1;
    do_cmd(1, 32'h50, 32'h1111_2222, 4'hF, 0, 2'b10, 1, 9);
    wait_rsp();
    b_never = 0;
    do_cmd(1, 32'h54, 32'h3333_4444, 4'hC, 0, 2'b00, 0, 3);
    wait_rsp();

    // asynchronous reset while awvalid is stuck high
    aw_lat = 100;
    do_cmd(1, 32'h60, 32'h7777_8888, 4'hF, 0, 2'b00, 0, 0);
    @(posedge aclk); #2;
    chk("mid_awvalid_high", awvalid, 1);
    #1 aresetn = 0;
    #1;
    chk("arst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
    chk("arst_data", {awaddr, wdata, wstrb, rsp_rdata}, 0);
    exp_q.delete();
    @(posedge aclk); #2;
    aresetn = 1; aw_lat = 0;
    repeat (5) @(posedge aclk); #2;
    chk("arst_no_rsp", rsp_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    rdata_v = 32'hCAFE_0042; rresp_v = 2'b00;
    do_cmd(0, 32'h70, 0, 0, 32'hCAFE_0042, 2'b00, 0, 3);
    wait_rsp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
